// File: rtl/sisc_mem_pkg.sv
// Shared types and constants for the SISC memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sisc_mem_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   // Memory read latency bounds; the wait counter is 3 bits wide.
   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 7;
   localparam int CNT_W    = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

endpackage

// File: rtl/sisc_mem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (fetch vs data) with a last-grant register.
// Latency: grant is combinational; last_gnt updates on the posedge where take is high.
// Backpressure: requesters hold req until served; a tie alternates so neither starves.
import sisc_mem_pkg::*;

module rr_arb2 (
   input  logic clk,
   input  logic rst_f,
   input  logic req_if,
   input  logic req_dm,
   input  logic take,
   output gnt_t gnt
);

   gnt_t last_gnt;

   // Single requester wins outright; a tie goes to whoever was not served last.
   always_comb begin
      gnt = GNT_IF;
      if (req_if && req_dm)
         gnt = (last_gnt == GNT_IF) ? GNT_DM : GNT_IF;
      else if (req_dm)
         gnt = GNT_DM;
   end

   // Remember the winner of every accepted grant; reset to IF so the first tie goes to DM.
   always_ff @(posedge clk) begin
      if (!rst_f)
         last_gnt <= GNT_IF;
      else if (take)
         last_gnt <= gnt;
   end

endmodule

// File: rtl/sisc_mem_ctrl.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Latency: req in cycle 0 -> mem_en cycle 1 -> capture cycle 1+WAIT_CYC -> done cycle 2+WAIT_CYC.
// Backpressure: requesters hold req until their done pulse; one access per WAIT_CYC+3 cycles.
import sisc_mem_pkg::*;

module sisc_mem_ctrl #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   generate
      if (WAIT_CYC < WAIT_MIN || WAIT_CYC > WAIT_MAX) begin : g_bad_wait
         $error("sisc_mem_ctrl: WAIT_CYC must be within 1..7");
      end
   endgenerate

   state_t             state, state_nxt;
   gnt_t               gnt, gnt_q;
   logic               take;
   logic [CNT_W-1:0]   cnt;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_f  (rst_f),
      .req_if (if_req),
      .req_dm (dm_req),
      .take   (take),
      .gnt    (gnt)
   );

   // Next-state logic; take marks the IDLE cycle in which a grant is accepted.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || dm_req) begin
               state_nxt = ACCESS;
               take      = 1'b1;
            end
         end
         ACCESS: begin
            if (cnt == CNT_W'(1))
               state_nxt = CAPTURE;
         end
         CAPTURE: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_f)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Grant capture and wait counter: the winner's request is frozen at grant time.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         gnt_q     <= GNT_IF;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else if (take) begin
         gnt_q     <= gnt;
         cnt       <= CNT_W'(WAIT_CYC);
         if (gnt == GNT_DM) begin
            mem_addr  <= dm_addr;
            mem_we    <= dm_we;
            mem_wdata <= dm_wdata;
         end else begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
         end
      end else if (state == ACCESS) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Strobe, busy and done pulses, all registered from the next-state decision.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         mem_en  <= 1'b0;
         busy    <= 1'b0;
         if_done <= 1'b0;
         dm_done <= 1'b0;
      end else begin
         mem_en  <= take;
         busy    <= (state_nxt != IDLE);
         if_done <= (state == CAPTURE) && (gnt_q == GNT_IF);
         dm_done <= (state == CAPTURE) && (gnt_q == GNT_DM);
      end
   end

   // Read data capture into the granted side only; stores leave both registers alone.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         if_rdata <= '0;
         dm_rdata <= '0;
      end else if (state == CAPTURE && !mem_we) begin
         if (gnt_q == GNT_IF)
            if_rdata <= mem_rdata;
         else
            dm_rdata <= mem_rdata;
      end
   end

endmodule
